// File: rtl/clk_enable_manager_if.sv
`default_nettype none
// ============================================================================
//  Module      : clk_enable_manager_if
//  Description : Lock input, increment-write port and clock-enable / reset
//                outputs of clk_enable_manager. The optional lock_loss_cnt
//                signal exists only when LOCK_LOSS_CNT_EN is defined.
//  Revision    : 1.0 - initial release
// ============================================================================
interface clk_enable_manager_if #(
    parameter int NUM_CH = 2,
    parameter int ACC_W  = 24
);
    logic              pll_lock_in;
    logic              inc_wr;
    logic [2:0]        inc_sel;
    logic [ACC_W-1:0]  inc_data;
    logic [NUM_CH-1:0] ce_out;
    logic              sys_rst;
    logic              locked;
`ifdef LOCK_LOSS_CNT_EN
    logic [7:0]        lock_loss_cnt;

    modport master (
        output pll_lock_in, inc_wr, inc_sel, inc_data,
        input  ce_out, sys_rst, locked, lock_loss_cnt
    );
    modport slave (
        input  pll_lock_in, inc_wr, inc_sel, inc_data,
        output ce_out, sys_rst, locked, lock_loss_cnt
    );
`else
    modport master (
        output pll_lock_in, inc_wr, inc_sel, inc_data,
        input  ce_out, sys_rst, locked
    );
    modport slave (
        input  pll_lock_in, inc_wr, inc_sel, inc_data,
        output ce_out, sys_rst, locked
    );
`endif
endinterface
`default_nettype wire

// File: rtl/clk_enable_manager.sv
`default_nettype none
// ============================================================================
//  Module      : clk_enable_manager
//  Description : Post-PLL clock manager. Synchronises and filters the PLL
//                lock, sequences the system reset from it, and produces
//                NUM_CH fractional clock enables from phase accumulators
//                (rate = inc / 2^ACC_W) with run-time programmable increments.
//                Optional feature macro: LOCK_LOSS_CNT_EN adds a saturating
//                8-bit count of RUN->WAIT lock losses (lock_loss_cnt).
//  Revision    : 1.0 - initial release
// ============================================================================
module clk_enable_manager #(
    parameter int               NUM_CH      = 2,
    parameter int               ACC_W       = 24,
    parameter logic [ACC_W-1:0] INC_DEFAULT = 24'h5A6B,
    parameter int               LOCK_FILT   = 16,
    parameter int               RST_HOLD    = 256
) (
    input  wire logic            clkin,
    input  wire logic            reset,
    clk_enable_manager_if.slave  bus
);

    // One shared counter serves both the filter and the hold phase
    localparam int c_CNT_MAX = (LOCK_FILT > RST_HOLD) ? LOCK_FILT : RST_HOLD;
    localparam int c_CNT_W   = (c_CNT_MAX > 1) ? $clog2(c_CNT_MAX) : 1;
    localparam logic [c_CNT_W-1:0] c_FILT_LAST = c_CNT_W'(LOCK_FILT - 1);
    localparam logic [c_CNT_W-1:0] c_HOLD_LAST = c_CNT_W'(RST_HOLD - 1);

    typedef enum logic [1:0] {
        ST_WAIT   = 2'd0,
        ST_FILTER = 2'd1,
        ST_HOLD   = 2'd2,
        ST_RUN    = 2'd3
    } state_t;

    state_t              r_state;
    logic [c_CNT_W-1:0]  r_cnt;
    logic                r_sync1;
    logic                r_lock_s;
    logic                r_sys_rst;
    logic                r_locked;
    logic [NUM_CH-1:0]   r_ce;
    logic                w_acc_run;

    // Two-flop synchroniser for the asynchronous PLL lock
    always_ff @(posedge clkin) begin
        if (reset) begin
            r_sync1  <= 1'b0;
            r_lock_s <= 1'b0;
        end else begin
            r_sync1  <= bus.pll_lock_in;
            r_lock_s <= r_sync1;
        end
    end

    // Lock qualification and reset sequencing; any lock loss drops to WAIT
    always_ff @(posedge clkin) begin
        if (reset) begin
            r_state   <= ST_WAIT;
            r_cnt     <= '0;
            r_sys_rst <= 1'b1;
            r_locked  <= 1'b0;
        end else begin
            case (r_state)
                ST_WAIT: begin
                    if (r_lock_s) begin
                        r_state <= ST_FILTER;
                        r_cnt   <= '0;
                    end
                end
                ST_FILTER: begin
                    if (!r_lock_s) begin
                        r_state <= ST_WAIT;
                    end else if (r_cnt == c_FILT_LAST) begin
                        r_state <= ST_HOLD;
                        r_cnt   <= '0;
                    end else begin
                        r_cnt <= r_cnt + c_CNT_W'(1);
                    end
                end
                ST_HOLD: begin
                    if (!r_lock_s) begin
                        r_state <= ST_WAIT;
                    end else if (r_cnt == c_HOLD_LAST) begin
                        r_state   <= ST_RUN;
                        r_sys_rst <= 1'b0;
                        r_locked  <= 1'b1;
                    end else begin
                        r_cnt <= r_cnt + c_CNT_W'(1);
                    end
                end
                ST_RUN: begin
                    if (!r_lock_s) begin
                        r_state   <= ST_WAIT;
                        r_sys_rst <= 1'b1;
                        r_locked  <= 1'b0;
                    end
                end
                default: begin
                    r_state   <= ST_WAIT;
                    r_cnt     <= '0;
                    r_sys_rst <= 1'b1;
                    r_locked  <= 1'b0;
                end
            endcase
        end
    end

    // Accumulators advance only while staying in HOLD/RUN; a lock loss there
    // means the FSM enters WAIT on this edge, so the accumulators clear too.
    assign w_acc_run = ((r_state == ST_HOLD) || (r_state == ST_RUN)) && r_lock_s;

    generate
        for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
            logic [ACC_W-1:0] r_acc;
            logic [ACC_W-1:0] r_inc;
            logic [ACC_W:0]   w_sum;

            assign w_sum = {1'b0, r_acc} + {1'b0, r_inc};

            // Increment register: out-of-range channel indices match nothing
            always_ff @(posedge clkin) begin
                if (reset) begin
                    r_inc <= INC_DEFAULT;
                end else if (bus.inc_wr && (bus.inc_sel == 3'(i))) begin
                    r_inc <= bus.inc_data;
                end
            end

            // Phase accumulator; the carry out is the registered clock enable
            always_ff @(posedge clkin) begin
                if (reset || !w_acc_run) begin
                    r_acc   <= '0;
                    r_ce[i] <= 1'b0;
                end else begin
                    r_acc   <= w_sum[ACC_W-1:0];
                    r_ce[i] <= w_sum[ACC_W];
                end
            end
        end
    endgenerate

`ifdef LOCK_LOSS_CNT_EN
    logic [7:0] r_loss_cnt;

    // Saturating count of lock losses out of RUN; only reset clears it
    always_ff @(posedge clkin) begin
        if (reset) begin
            r_loss_cnt <= 8'h00;
        end else if ((r_state == ST_RUN) && !r_lock_s && (r_loss_cnt != 8'hFF)) begin
            r_loss_cnt <= r_loss_cnt + 8'h01;
        end
    end

    assign bus.lock_loss_cnt = r_loss_cnt;
`endif

    assign bus.ce_out  = r_ce;
    assign bus.sys_rst = r_sys_rst;
    assign bus.locked  = r_locked;

endmodule
`default_nettype wire
